// File: rtl/line_mem_bridge_if.sv
// Cache-line request channel and word-wide main-memory channel of the line/memory bridge.
// A transfer happens on a rising edge where the producer's valid and the consumer's ready are both 1.
interface line_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128
);
  logic              req_valid;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic              req_ready;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;
  logic              busy;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_rw, req_addr, req_data, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, busy, mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, busy, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/line_mem_bridge.sv
// Splits a 4-word cache line read/writeback into four back-to-back word beats on main memory.
// All outputs are registered; state is exposed on state_dbg (0=IDLE, 1=BEAT, 2=DONE).
module line_mem_bridge #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  line_mem_bridge_if.slave  bus,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [1:0]          cnt_nxt;
  logic [ADDR_W-5:0]   addr_q;
  logic                rw_q;
  logic [LINE_W-1:0]   wline;
  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   rd_next;

  assign cnt_nxt   = cnt + 2'd1;
  assign state_dbg = state;

  // Read line with the word arriving this beat merged in.
  always_comb begin
    rd_next = rd_line;
    rd_next[int'(cnt)*WORD_W +: WORD_W] = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      addr_q         <= '0;
      rw_q           <= 1'b0;
      wline          <= '0;
      rd_line        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.busy       <= 1'b0;
      bus.mem_valid  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= BEAT;
            cnt           <= 2'd0;
            addr_q        <= bus.req_addr[ADDR_W-1:4];
            rw_q          <= bus.req_rw;
            wline         <= bus.req_data;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= bus.req_rw;
            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:4], 4'b0000};
            bus.mem_wdata <= bus.req_data[WORD_W-1:0];
          end
        end
        BEAT: begin
          if (bus.mem_ready) begin
            if (!rw_q) rd_line <= rd_next;
            if (cnt == 2'd3) begin
              // Last beat: publish the line (reads only) together with the completion pulse.
              state          <= DONE;
              bus.mem_valid  <= 1'b0;
              bus.mem_we     <= 1'b0;
              bus.resp_valid <= 1'b1;
              if (!rw_q) bus.resp_data <= rd_next;
            end else begin
              cnt           <= cnt_nxt;
              bus.mem_addr  <= {addr_q, cnt_nxt, 2'b00};
              bus.mem_wdata <= wline[int'(cnt_nxt)*WORD_W +: WORD_W];
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          cnt            <= 2'd0;
          bus.resp_valid <= 1'b0;
          bus.busy       <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          cnt            <= 2'd0;
          bus.resp_valid <= 1'b0;
          bus.busy       <= 1'b0;
          bus.req_ready  <= 1'b1;
          bus.mem_valid  <= 1'b0;
          bus.mem_we     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_mem_bridge.sv
// Directed bench for line_mem_bridge: reset, read, writeback, stall, back-to-back request, mid-transfer reset.
module tb_line_mem_bridge;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_chk  = 0;
  int         n_pass = 0;

  line_mem_bridge_if #(.ADDR_W(32), .WORD_W(32), .LINE_W(128)) bus ();

  line_mem_bridge #(.ADDR_W(32), .WORD_W(32), .LINE_W(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  128'(bus.req_ready),  128'd1);
    check({tag, " resp_valid"}, 128'(bus.resp_valid), 128'd0);
    check({tag, " busy"},       128'(bus.busy),       128'd0);
    check({tag, " mem_valid"},  128'(bus.mem_valid),  128'd0);
    check({tag, " mem_we"},     128'(bus.mem_we),     128'd0);
    check({tag, " mem_addr"},   128'(bus.mem_addr),   128'd0);
    check({tag, " mem_wdata"},  128'(bus.mem_wdata),  128'd0);
    check({tag, " resp_data"},  bus.resp_data,        128'd0);
    check({tag, " state"},      128'(state_dbg),      128'd0);
  endtask

  logic [127:0] line_a;
  logic [127:0] line_b;

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    line_a = 128'h000000A3_000000A2_000000A1_000000A0;
    line_b = 128'h000000B3_000000B2_000000B1_000000B0;

    // Asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle req_ready", 128'(bus.req_ready), 128'd1);

    // Read 0x1238, memory always ready
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 32'h0000_1238;
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd beat%0d mem_valid", i), 128'(bus.mem_valid), 128'd1);
      check($sformatf("rd beat%0d mem_we", i),    128'(bus.mem_we),    128'd0);
      check($sformatf("rd beat%0d mem_addr", i),  128'(bus.mem_addr),  128'(32'h1230 + 4 * i));
      check($sformatf("rd beat%0d req_ready", i), 128'(bus.req_ready), 128'd0);
      check($sformatf("rd beat%0d busy", i),      128'(bus.busy),      128'd1);
      bus.mem_rdata = 32'hA0 + 32'(i);
      tick();
    end
    check("rd done resp_valid", 128'(bus.resp_valid), 128'd1);
    check("rd done mem_valid",  128'(bus.mem_valid),  128'd0);
    check("rd done busy",       128'(bus.busy),       128'd1);
    check("rd done req_ready",  128'(bus.req_ready),  128'd0);
    check("rd done resp_data",  bus.resp_data,        line_a);
    check("rd done state",      128'(state_dbg),      128'd2);
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("rd idle resp_valid", 128'(bus.resp_valid), 128'd0);
    check("rd idle req_ready",  128'(bus.req_ready),  128'd1);
    check("rd idle busy",       128'(bus.busy),       128'd0);
    check("rd idle mem_valid",  128'(bus.mem_valid),  128'd0);
    check("rd idle resp_data",  bus.resp_data,        line_a);
    tick();
    check("rd hold resp_data",  bus.resp_data,        line_a);

    // Writeback to 0x8000_0000
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 32'h8000_0000;
    bus.req_data  = 128'h44444444_33333333_22222222_11111111;
    tick();
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr beat%0d mem_valid", i), 128'(bus.mem_valid), 128'd1);
      check($sformatf("wr beat%0d mem_we", i),    128'(bus.mem_we),    128'd1);
      check($sformatf("wr beat%0d mem_addr", i),  128'(bus.mem_addr),  128'(32'h8000_0000 + 4 * i));
      check($sformatf("wr beat%0d mem_wdata", i), 128'(bus.mem_wdata), 128'(32'h1111_1111 * (i + 1)));
      tick();
    end
    check("wr done resp_valid", 128'(bus.resp_valid), 128'd1);
    check("wr done mem_valid",  128'(bus.mem_valid),  128'd0);
    check("wr done resp_data",  bus.resp_data,        line_a);
    tick();
    check("wr idle resp_valid", 128'(bus.resp_valid), 128'd0);
    check("wr idle resp_data",  bus.resp_data,        line_a);

    // Read 0x2000 with a 3-cycle stall on beat 2; garbage rdata while stalled
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 32'h0000_2004;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_0000;
        for (int s = 0; s < 3; s++) begin
          check($sformatf("stall%0d mem_valid", s),  128'(bus.mem_valid),  128'd1);
          check($sformatf("stall%0d mem_addr", s),   128'(bus.mem_addr),   128'h2008);
          check($sformatf("stall%0d resp_valid", s), 128'(bus.resp_valid), 128'd0);
          tick();
        end
        bus.mem_ready = 1'b1;
      end
      check($sformatf("st beat%0d mem_addr", i), 128'(bus.mem_addr), 128'(32'h2000 + 4 * i));
      bus.mem_rdata = 32'hB0 + 32'(i);
      tick();
    end
    check("st done resp_valid", 128'(bus.resp_valid), 128'd1);
    check("st done resp_data",  bus.resp_data,        line_b);
    tick();
    check("st idle resp_valid", 128'(bus.resp_valid), 128'd0);

    // req_valid held high: second request only accepted in the IDLE cycle after DONE
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 32'h0000_3000;
    bus.mem_rdata = 32'h0000_00C0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b beat%0d req_ready", i), 128'(bus.req_ready), 128'd0);
      check($sformatf("b2b beat%0d mem_addr", i),  128'(bus.mem_addr),  128'(32'h3000 + 4 * i));
      tick();
    end
    check("b2b done resp_valid", 128'(bus.resp_valid), 128'd1);
    check("b2b done mem_valid",  128'(bus.mem_valid),  128'd0);
    check("b2b done resp_data",  bus.resp_data,        {4{32'h0000_00C0}});
    bus.req_addr = 32'h0000_4000;
    tick();
    check("b2b idle req_ready",  128'(bus.req_ready), 128'd1);
    check("b2b idle mem_valid",  128'(bus.mem_valid), 128'd0);
    tick();
    bus.req_valid = 1'b0;
    check("b2b 2nd mem_valid",   128'(bus.mem_valid), 128'd1);
    check("b2b 2nd mem_addr",    128'(bus.mem_addr),  128'h4000);
    bus.mem_rdata = 32'h0000_0055;
    repeat (4) tick();
    check("b2b 2nd resp_valid",  128'(bus.resp_valid), 128'd1);
    check("b2b 2nd resp_data",   bus.resp_data,         {4{32'h0000_0055}});
    tick();

    // Reset pulsed during beat 1 of a read
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 32'h0000_5000;
    bus.mem_rdata = 32'h0000_0077;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("abort beat1 mem_addr", 128'(bus.mem_addr), 128'h5004);
    bus.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort async");
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check("abort hold resp_valid", 128'(bus.resp_valid), 128'd0);
    check("abort hold mem_valid",  128'(bus.mem_valid),  128'd0);
    rst_n = 1'b1;
    tick();
    check("abort rel resp_valid",  128'(bus.resp_valid), 128'd0);
    check("abort rel mem_valid",   128'(bus.mem_valid),  128'd0);
    check("abort rel req_ready",   128'(bus.req_ready),  128'd1);

    // Fresh read after the aborted one
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_600C;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post beat%0d mem_addr", i), 128'(bus.mem_addr), 128'(32'h6000 + 4 * i));
      bus.mem_rdata = 32'h60 + 32'(i);
      tick();
    end
    check("post done resp_valid", 128'(bus.resp_valid), 128'd1);
    check("post done resp_data",  bus.resp_data, 128'h00000063_00000062_00000061_00000060);
    tick();
    check("post idle req_ready",  128'(bus.req_ready), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
